// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: {Bout, DIFF} = A - B - Bin, LSB first, one full-subtractor
// step per clock, with a start/busy/done handshake and results held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// RUN   | one bit-step per clock, W steps total
// DONE  | single-cycle completion; start here re-enters RUN back-to-back
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] DIFF,
    output logic         Bout,
    output logic         ovf
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_sh, b_sh, res;
    logic [CW-1:0]  cnt;
    logic           br;
    logic           accept, last;
    logic           a_i, b_i, d_i, br_nxt;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == CW'(W - 1));

    assign a_i    = a_sh[0];
    assign b_i    = b_sh[0];
    assign d_i    = a_i ^ b_i ^ br;
    assign br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            DIFF <= '0;
            Bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= B;
            br   <= Bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {d_i, res[W-1:1]};
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            // On the MSB step br is still the borrow into the MSB, so ovf is formed here.
            if (last) begin
                DIFF <= {d_i, res[W-1:1]};
                Bout <= br_nxt;
                ovf  <= br ^ br_nxt;
            end
        end
    end

endmodule
